// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C command arbiter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, requester count, address/data/counter widths,
// and small helpers to convert a one-hot grant to an index and advance the
// round-robin pointer.
package i2c_arb_pkg;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | REQ_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // The requester after the one just granted becomes the priority holder.
    function automatic logic [REQ_IDX_W-1:0] next_ptr(input logic [REQ_IDX_W-1:0] idx);
        return (idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : idx + REQ_IDX_W'(1);
    endfunction

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Round-robin picker: one-hot grant starting the search at requester 'ptr'.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides whether the grant is taken.
//
// Ports:
//   req   - request vector, bit n = requester n
//   ptr   - index of the requester currently holding priority
//   grant - one-hot winner (all zero when req is zero)
//   valid - at least one request present
module i2c_arb_rr_pick
    import i2c_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 valid
);

    logic [NUM_REQ-1:0] rot_req;
    logic [NUM_REQ-1:0] rot_gnt;

    // Rotate so the priority holder sits at bit 0, isolate the lowest set
    // bit, then rotate the result back into requester numbering.
    always_comb begin
        rot_req = NUM_REQ'({req, req} >> ptr);
        rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
        grant   = NUM_REQ'({rot_gnt, rot_gnt} >> (NUM_REQ - 32'(ptr)));
    end

    assign valid = |req;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates two requesters onto one I2C master, one transaction at a time.
// Latency: request->m_start 2 cycles; m_done->rsp_valid 1 cycle.
// Backpressure: req_ready pulses only in IDLE with m_busy low; losers wait.
//
// Ports:
//   clk, reset                     - single clock, synchronous active-high reset
//   req_valid / req_ready          - per-requester request and accept pulse
//   reqN_addr / reqN_rw / reqN_wdata - per-requester command fields
//   rsp_valid / rsp_nack / rsp_timeout / rsp_rdata - completion pulse and status
//   m_start / m_addr / m_rw / m_wdata - command to the I2C master
//   m_busy / m_done / m_nack / m_rdata - status from the I2C master
//
// Build option: define I2C_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts
// after TIMEOUT_CYCLES cycles without m_done.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic                req0_rw,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic                req1_rw,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic [NUM_REQ-1:0]  req_ready,
    output logic [NUM_REQ-1:0]  rsp_valid,
    output logic                rsp_nack,
    output logic                rsp_timeout,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                m_start,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_rw,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_busy,
    input  logic                m_done,
    input  logic                m_nack,
    input  logic [DATA_W-1:0]   m_rdata
);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 pick_vld;
    logic [REQ_IDX_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0]   win;
    logic                 take;
    logic                 tmo_hit;

    i2c_arb_rr_pick u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .valid (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // take is gated by reset so req_ready stays low while reset is held,
    // even if the state register already reads IDLE.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld && !m_busy && !reset) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (m_done || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = take ? pick_gnt : '0;

    // Command fields are captured at grant and held until the next grant,
    // which keeps them stable for the whole master transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            win       <= '0;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_wdata   <= '0;
            rsp_valid <= '0;
            rsp_nack  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            m_start   <= (state == ISSUE);
            rsp_valid <= '0;
            if (take) begin
                win     <= pick_gnt;
                rr_ptr  <= next_ptr(onehot_to_idx(pick_gnt));
                m_addr  <= pick_gnt[1] ? req1_addr  : req0_addr;
                m_rw    <= pick_gnt[1] ? req1_rw    : req0_rw;
                m_wdata <= pick_gnt[1] ? req1_wdata : req0_wdata;
            end
            if (state == WAIT) begin
                // m_done takes precedence over a watchdog expiring the same cycle.
                if (m_done) begin
                    rsp_valid <= win;
                    rsp_nack  <= m_nack;
                    rsp_rdata <= m_rw ? m_rdata : '0;
                end else if (tmo_hit) begin
                    rsp_valid <= win;
                    rsp_nack  <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;

    // Counts WAIT cycles from 0; expiry lands on the TIMEOUT_CYCLES-th cycle.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TIMEOUT_CYCLES - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_timeout <= 1'b0;
        end else if (state == WAIT) begin
            if (m_done) begin
                rsp_timeout <= 1'b0;
            end else if (tmo_hit) begin
                rsp_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: directed vector table, hand-written
// reset/busy/stall sequences, and randomized transactions against a
// transaction-level round-robin model.
module tb_i2c_req_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [6:0] req0_addr, req1_addr;
    logic       req0_rw, req1_rw;
    logic [7:0] req0_wdata, req1_wdata;
    logic [1:0] req_ready, rsp_valid;
    logic       rsp_nack, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       m_start;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_wdata;
    logic       m_busy, m_done, m_nack;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    i2c_req_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req0_addr(req0_addr), .req0_rw(req0_rw), .req0_wdata(req0_wdata),
        .req1_addr(req1_addr), .req1_rw(req1_rw), .req1_wdata(req1_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata),
        .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    int checks = 0;
    int errors = 0;
    int prio   = 0;   // model: requester holding round-robin priority

    typedef struct {
        logic [1:0] rv;
        logic [6:0] a0;
        logic [6:0] a1;
        logic       rw0;
        logic       rw1;
        logic [7:0] w0;
        logic [7:0] w1;
        int         dly;
        logic       nk;
        logic [7:0] rd;
        logic [1:0] eg;
        logic [7:0] erd;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: sole requester wins; with both asking, the priority holder wins.
    function automatic logic [1:0] model_grant(input logic [1:0] rv);
        int w;
        w = (rv == 2'b11) ? prio : (rv[1] ? 1 : 0);
        return 2'(1 << w);
    endfunction

    // One full transaction starting in IDLE at posedge+1; returns at posedge+1
    // of the first IDLE cycle after the response.
    task automatic txn(input string tag, input logic [1:0] rv, input int dly,
                       input logic nk, input logic [7:0] rd,
                       input logic [1:0] eg, input logic [7:0] erd);
        logic [6:0] ea;
        logic       erw;
        logic [7:0] ew;
        logic       bad;
        ea  = eg[1] ? req1_addr  : req0_addr;
        erw = eg[1] ? req1_rw    : req0_rw;
        ew  = eg[1] ? req1_wdata : req0_wdata;
        bad = 1'b0;
        req_valid = rv;
        m_done    = 1'b0;
        @(negedge clk);
        chk($sformatf("%s.ready", tag), 32'(req_ready), 32'(eg));
        step();
        req_valid = rv & ~eg;
        @(negedge clk);
        if (req_ready !== 2'b00 || m_start !== 1'b0) bad = 1'b1;
        step();
        @(negedge clk);
        chk($sformatf("%s.m_start", tag), 32'(m_start), 32'(1'b1));
        chk($sformatf("%s.m_addr", tag), 32'(m_addr), 32'(ea));
        chk($sformatf("%s.m_rw", tag), 32'(m_rw), 32'(erw));
        chk($sformatf("%s.m_wdata", tag), 32'(m_wdata), 32'(ew));
        repeat (dly) begin
            step();
            @(negedge clk);
            if (req_ready !== 2'b00 || m_start !== 1'b0 || rsp_valid !== 2'b00 || m_addr !== ea) bad = 1'b1;
        end
        step();
        m_done  = 1'b1;
        m_nack  = nk;
        m_rdata = rd;
        @(negedge clk);
        if (req_ready !== 2'b00 || m_start !== 1'b0 || rsp_valid !== 2'b00 || m_addr !== ea) bad = 1'b1;
        step();
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_rdata = 8'h00;
        @(negedge clk);
        chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(eg));
        chk($sformatf("%s.rsp_nack", tag), 32'(rsp_nack), 32'(nk));
        chk($sformatf("%s.rsp_timeout", tag), 32'(rsp_timeout), 32'(1'b0));
        chk($sformatf("%s.rsp_rdata", tag), 32'(rsp_rdata), 32'(erd));
        chk($sformatf("%s.quiet", tag), 32'(bad), 32'(1'b0));
        prio = eg[0] ? 1 : 0;
        step();
    endtask

    // Transaction where the master never completes on its own.
    task automatic txn_stall(input logic [1:0] eg);
        logic erw;
        erw = eg[1] ? req1_rw : req0_rw;
        req_valid = eg;
        @(negedge clk);
        chk("stall.ready", 32'(req_ready), 32'(eg));
        step();
        req_valid = 2'b00;
        step();
        @(negedge clk);
        chk("stall.m_start", 32'(m_start), 32'(1'b1));
`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int  n;
            logic got;
            n   = 0;
            got = 1'b0;
            while (n < 20 && !got) begin
                step();
                n++;
                @(negedge clk);
                if (rsp_valid !== 2'b00) got = 1'b1;
            end
            chk("tmo.cycles", 32'(n), 32'(8));
            chk("tmo.rsp_valid", 32'(rsp_valid), 32'(eg));
            chk("tmo.rsp_nack", 32'(rsp_nack), 32'(1'b1));
            chk("tmo.rsp_timeout", 32'(rsp_timeout), 32'(1'b1));
            chk("tmo.rsp_rdata", 32'(rsp_rdata), 32'(8'h00));
        end
`else
        begin
            logic bad;
            bad = 1'b0;
            repeat (30) begin
                step();
                @(negedge clk);
                if (rsp_valid !== 2'b00) bad = 1'b1;
            end
            chk("stall.no_rsp", 32'(bad), 32'(1'b0));
            step();
            m_done  = 1'b1;
            m_rdata = 8'h6B;
            step();
            m_done  = 1'b0;
            m_rdata = 8'h00;
            @(negedge clk);
            chk("stall.rsp_valid", 32'(rsp_valid), 32'(eg));
            chk("stall.rsp_nack", 32'(rsp_nack), 32'(1'b0));
            chk("stall.rsp_timeout", 32'(rsp_timeout), 32'(1'b0));
            chk("stall.rsp_rdata", 32'(rsp_rdata), 32'(erw ? 8'h6B : 8'h00));
        end
`endif
        prio = eg[0] ? 1 : 0;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'(2'b00));
        chk($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(2'b00));
        chk($sformatf("%s.rsp_nack", tag), 32'(rsp_nack), 32'(1'b0));
        chk($sformatf("%s.rsp_timeout", tag), 32'(rsp_timeout), 32'(1'b0));
        chk($sformatf("%s.rsp_rdata", tag), 32'(rsp_rdata), 32'(8'h00));
        chk($sformatf("%s.m_start", tag), 32'(m_start), 32'(1'b0));
        chk($sformatf("%s.m_addr", tag), 32'(m_addr), 32'(7'h00));
        chk($sformatf("%s.m_rw", tag), 32'(m_rw), 32'(1'b0));
        chk($sformatf("%s.m_wdata", tag), 32'(m_wdata), 32'(8'h00));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic       bad;
        logic [1:0] rv;
        logic [1:0] eg;
        logic [7:0] rd;
        logic       nk;

        // {rv, a0, a1, rw0, rw1, w0, w1, dly, nack, m_rdata, exp grant, exp rdata}
        vt[0] = '{2'b01, 7'h50, 7'h00, 1'b0, 1'b0, 8'hAA, 8'h00, 2, 1'b0, 8'h77, 2'b01, 8'h00};
        vt[1] = '{2'b10, 7'h00, 7'h3C, 1'b0, 1'b1, 8'h00, 8'h00, 1, 1'b0, 8'h5A, 2'b10, 8'h5A};
        vt[2] = '{2'b11, 7'h21, 7'h42, 1'b0, 1'b1, 8'h11, 8'h99, 0, 1'b0, 8'hC3, 2'b01, 8'h00};
        vt[3] = '{2'b11, 7'h21, 7'h42, 1'b0, 1'b1, 8'h11, 8'h99, 3, 1'b0, 8'hC3, 2'b10, 8'hC3};
        vt[4] = '{2'b11, 7'h21, 7'h42, 1'b0, 1'b1, 8'h11, 8'h99, 6, 1'b0, 8'hC3, 2'b01, 8'h00};
        vt[5] = '{2'b11, 7'h21, 7'h42, 1'b0, 1'b1, 8'h11, 8'h99, 1, 1'b0, 8'hC3, 2'b10, 8'hC3};
        vt[6] = '{2'b01, 7'h12, 7'h00, 1'b0, 1'b0, 8'h34, 8'h00, 0, 1'b1, 8'h55, 2'b01, 8'h00};
        vt[7] = '{2'b01, 7'h13, 7'h00, 1'b1, 1'b0, 8'h00, 8'h00, 4, 1'b0, 8'hE7, 2'b01, 8'hE7};
        vt[8] = '{2'b11, 7'h13, 7'h7F, 1'b1, 1'b0, 8'h00, 8'hFF, 2, 1'b0, 8'h12, 2'b10, 8'h00};

        reset = 1'b1; req_valid = 2'b11; m_busy = 1'b0; m_done = 1'b0;
        m_nack = 1'b0; m_rdata = 8'h00;
        req0_addr = 7'h00; req0_rw = 1'b0; req0_wdata = 8'h00;
        req1_addr = 7'h00; req1_rw = 1'b0; req1_wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        step();
        reset = 1'b0;
        req_valid = 2'b00;
        prio = 0;

        for (int i = 0; i < 9; i++) begin
            req0_addr = vt[i].a0; req1_addr = vt[i].a1;
            req0_rw = vt[i].rw0;  req1_rw = vt[i].rw1;
            req0_wdata = vt[i].w0; req1_wdata = vt[i].w1;
            txn($sformatf("vec%0d", i), vt[i].rv, vt[i].dly, vt[i].nk, vt[i].rd, vt[i].eg, vt[i].erd);
        end

        // Master busy holds off the grant.
        req_valid = 2'b01; m_busy = 1'b1; bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (req_ready !== 2'b00) bad = 1'b1;
            step();
        end
        chk("busy.no_grant", 32'(bad), 32'(1'b0));
        m_busy = 1'b0;
        req0_addr = 7'h2A; req0_rw = 1'b0; req0_wdata = 8'h5C;
        eg = model_grant(2'b01);
        txn("busy.after", 2'b01, 1, 1'b0, 8'h00, eg, 8'h00);

        // Stray m_done in IDLE is ignored.
        req_valid = 2'b00; m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hFF;
        step();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        @(negedge clk);
        chk("stray.rsp_valid", 32'(rsp_valid), 32'(2'b00));
        chk("stray.m_start", 32'(m_start), 32'(1'b0));
        step();
        req1_addr = 7'h11; req1_rw = 1'b1; req1_wdata = 8'h00;
        eg = model_grant(2'b10);
        txn("stray.after", 2'b10, 0, 1'b0, 8'h9D, eg, 8'h9D);

        // Master that never completes.
        req0_addr = 7'h44; req0_rw = 1'b1;
        txn_stall(model_grant(2'b01));

        // Reset while in WAIT drops the transaction silently.
        req_valid = 2'b10; req1_addr = 7'h66; req1_rw = 1'b1;
        @(negedge clk);
        chk("rstw.ready", 32'(req_ready), 32'(model_grant(2'b10)));
        step();
        req_valid = 2'b00;
        repeat (3) step();
        reset = 1'b1; m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hAB;
        step();
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("rstw");
        bad = 1'b0;
        repeat (4) begin
            step();
            @(negedge clk);
            if (rsp_valid !== 2'b00) bad = 1'b1;
        end
        chk("rstw.no_rsp", 32'(bad), 32'(1'b0));
        step();
        prio = 0;
        req0_addr = 7'h01; req0_rw = 1'b0; req0_wdata = 8'h0F;
        req1_addr = 7'h02; req1_rw = 1'b0; req1_wdata = 8'hF0;
        txn("rstw.after", 2'b11, 1, 1'b0, 8'h00, 2'b01, 8'h00);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            rv = 2'($urandom_range(1, 3));
            req0_addr = 7'($urandom); req1_addr = 7'($urandom);
            req0_rw = 1'($urandom);   req1_rw = 1'($urandom);
            req0_wdata = 8'($urandom); req1_wdata = 8'($urandom);
            rd = 8'($urandom);
            nk = 1'($urandom);
            eg = model_grant(rv);
            txn($sformatf("rnd%0d", i), rv, int'($urandom_range(0, 6)), nk, rd, eg,
                (eg[1] ? req1_rw : req0_rw) ? rd : 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the max cycles spent in WAIT before abort (16-bit).
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 req_valid  in  2  per-requester transaction request, bit n = requester n.
REQ-005 req0_addr/req1_addr  in  7 each  7-bit target slave address.
REQ-006 req0_rw/req1_rw  in  1 each  1 = read, 0 = write.
REQ-007 req0_wdata/req1_wdata  in  8 each  write byte.
REQ-008 req_ready  out  2  one-cycle accept pulse, bit n = requester n.
REQ-009 rsp_valid  out  2  one-cycle completion pulse, bit n = requester n.
REQ-010 rsp_nack  out  1  status qualified by rsp_valid: 1 = slave NACK or timeout.
REQ-011 rsp_timeout  out  1  status qualified by rsp_valid: 1 = aborted by watchdog.
REQ-012 rsp_rdata  out  8  read byte qualified by rsp_valid.
REQ-013 m_start  out  1  one-cycle command pulse to the I2C master.
REQ-014 m_addr/m_rw/m_wdata  out  7/1/8  command fields, held stable from m_start until m_done.
REQ-015 m_busy  in  1  master busy.
REQ-016 m_done  in  1  one-cycle master completion pulse.
REQ-017 m_nack/m_rdata  in  1/8  master status, valid with m_done.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid and m_busy=0, SHALL pick a winner, latch its fields, pulse its req_ready bit, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: the last granted requester has lowest priority; after reset requester 0 has priority.
REQ-021 Simultaneous requests SHALL grant the priority holder; the loser SHALL stay pending with no req_ready.
REQ-022 ISSUE: SHALL pulse m_start for exactly one cycle, then go to WAIT.
REQ-023 WAIT: on m_done, SHALL latch m_nack/m_rdata and go to RESP; m_done outside WAIT SHALL be ignored.
REQ-024 RESP: SHALL pulse the winner's rsp_valid bit for one cycle, then go to IDLE.
REQ-025 Request-to-m_start latency SHALL be 2 cycles (grant cycle, ISSUE cycle).
REQ-026 m_done-to-rsp_valid latency SHALL be 1 cycle.
REQ-027 At most one transaction SHALL be outstanding; req_ready SHALL never assert outside IDLE.
REQ-028 rsp_rdata SHALL be 0 for write transactions.
REQ-029 The round-robin pointer SHALL update only on grant.

Reset
REQ-030 reset SHALL force state IDLE and the RR pointer to requester 0.
REQ-031 reset SHALL clear req_ready, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata, m_start, m_addr, m_rw, m_wdata, and the timeout counter.
REQ-032 Reset mid-transaction SHALL drop it silently, with no rsp_valid.

Configuration
REQ-033 With I2C_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles; on reaching TIMEOUT_CYCLES without m_done it SHALL go to RESP with rsp_nack=1, rsp_timeout=1, rsp_rdata=0.
REQ-034 m_done arriving in the same cycle the count is reached SHALL win (normal completion).
REQ-035 Without I2C_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, rsp_timeout SHALL be tied 0, and no counter SHALL exist.

Structure
REQ-036 Package i2c_arb_pkg SHALL hold the FSM state enum, NUM_REQ=2, and the address/data width constants.
REQ-037 The round-robin picker SHALL be sub-module i2c_arb_rr_pick (inputs req, ptr; outputs one-hot grant, valid).

Verification
REQ-038 req_valid=01, req0 addr 0x50, write 0xAA, m_done with m_nack=0 -> req_ready=01; m_start 2 cycles later with m_addr=0x50, m_wdata=0xAA; rsp_valid=01 and rsp_nack=0 one cycle after m_done.
REQ-039 req_valid=11 held continuously over 4 transactions -> grants 0,1,0,1.
REQ-040 req1 read at addr 0x3C, m_done with m_rdata=0x5A -> rsp_valid=10, rsp_rdata=0x5A.
REQ-041 m_done with m_nack=1 -> rsp_nack=1, rsp_timeout=0; with TIMEOUT_EN and TIMEOUT_CYCLES=8 and no m_done -> rsp_valid after 8 WAIT cycles with rsp_nack=1, rsp_timeout=1.
REQ-042 reset asserted during WAIT -> no rsp_valid; all outputs 0; next request is granted to requester 0.
